// File: rtl/gtx_test_seq_ctrl_pkg.sv
// Shared types and default timing for the GTX loopback test sequencer.
// The sequencer states use a 3-bit encoding.
package gtx_test_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    localparam int DEF_CHNL_NUM   = 8;
    localparam int DEF_RST_CYC    = 64;
    localparam int DEF_SETTLE_CYC = 4096;
    localparam int DEF_DRAIN_CYC  = 256;
    localparam int DEF_ERR_W      = 16;

    // The phase counter must hold a full 32-bit run_cycles value.
    localparam int CNT_W = 32;

endpackage

// File: rtl/gtx_test_seq_ctrl_err_cnt.sv
// Per-lane saturating error counter. clr has priority.
// When the counter is cleared it stays at zero; otherwise it counts en & inc up to all-ones.
module gtx_err_cnt_sat #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [ERR_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && inc && (cnt != '1))
            cnt <= cnt + ERR_W'(1);
    end

endmodule

// File: rtl/gtx_test_seq_ctrl.sv
// Loopback test sequencer: resets gen/chk, waits for link settle, runs a timed
// window, drains, then reports per-lane error counts and overall pass.
module gtx_test_seq_ctrl
    import gtx_test_seq_ctrl_pkg::*;
#(
    parameter int CHNL_NUM   = DEF_CHNL_NUM,
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic                      usrclk,
    input  logic                      usrrst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               run_cycles,
    input  logic [7:0]                test_len,
    input  logic [CHNL_NUM-1:0]       chnl_en,
    input  logic [CHNL_NUM-1:0]       err_flag,
    output logic                      gen_rst_n,
    output logic [7:0]                test_len_ctrl,
    output logic                      test_run_ctrl,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      aborted,
    output logic [CHNL_NUM-1:0]       chnl_fail,
    output logic [CHNL_NUM*ERR_W-1:0] err_cnt
);

    seq_state_t          state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [31:0]         run_len;
    logic [CHNL_NUM-1:0] en_lat;
    logic [CHNL_NUM-1:0] lane_hit;
    logic                cnt_win;
    logic                cnt_clr;
    logic                active;

    assign cnt_win = (state == ST_RUN) || (state == ST_DRAIN);
    assign active  = (state == ST_RESET) || (state == ST_SETTLE) || cnt_win;
    assign cnt_clr = (state == ST_IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RESET;
            ST_RESET:  if (cnt == CNT_W'(RST_CYC - 1)) state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = ST_RUN;
            // run_len of zero never matches, so RUN only ends on abort
            ST_RUN:    if ((run_len != '0) && (cnt == run_len - 32'd1)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (cnt == CNT_W'(DRAIN_CYC - 1)) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort && active)
            state_nxt = ST_DONE;
    end

    always_ff @(posedge usrclk or posedge usrrst) begin
        if (usrrst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            run_len       <= '0;
            en_lat        <= '0;
            test_len_ctrl <= '0;
            gen_rst_n     <= 1'b0;
            test_run_ctrl <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            aborted       <= 1'b0;
            chnl_fail     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= ((state_nxt != state) || (state == ST_IDLE)) ? '0 : cnt + CNT_W'(1);

            // Control outputs are registered from the next state so they line up with it
            gen_rst_n     <= (state_nxt != ST_RESET);
            test_run_ctrl <= (state_nxt == ST_RUN);
            busy          <= (state_nxt != ST_IDLE);
            done          <= (state_nxt == ST_DONE);

            if (cnt_clr) begin
                run_len       <= run_cycles;
                en_lat        <= chnl_en;
                test_len_ctrl <= test_len;
                pass          <= 1'b0;
                aborted       <= 1'b0;
                chnl_fail     <= '0;
            end

            if (state_nxt == ST_DONE) begin
                aborted   <= abort;
                chnl_fail <= lane_hit & en_lat;
                pass      <= ~abort & ~|(lane_hit & en_lat);
            end
        end
    end

    // lane_hit folds in this cycle's strobe so a final-cycle error is not missed
    for (genvar i = 0; i < CHNL_NUM; i++) begin : g_lane
        gtx_err_cnt_sat #(.ERR_W(ERR_W)) u_cnt (
            .clk (usrclk),
            .rst (usrrst),
            .clr (cnt_clr),
            .en  (cnt_win),
            .inc (err_flag[i]),
            .cnt (err_cnt[i*ERR_W +: ERR_W])
        );
        assign lane_hit[i] = (|err_cnt[i*ERR_W +: ERR_W]) | (cnt_win & err_flag[i]);
    end

endmodule

// File: tb/tb_gtx_test_seq_ctrl.sv
// Bench for gtx_test_seq_ctrl: timeline-arithmetic reference model with
// randomized error strobes, aborts and stray starts, plus directed scenarios.
module tb_gtx_test_seq_ctrl;

    localparam int CH   = 8;
    localparam int EW   = 4;
    localparam int RST  = 4;
    localparam int SET  = 8;
    localparam int DRN  = 4;
    localparam int EMAX = (1 << EW) - 1;

    localparam int PH_IDLE = 0, PH_RESET = 1, PH_SETTLE = 2, PH_RUN = 3, PH_DRAIN = 4, PH_DONE = 5;

    logic           usrclk = 1'b0;
    logic           usrrst = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [31:0]    run_cycles = '0;
    logic [7:0]     test_len = '0;
    logic [CH-1:0]  chnl_en = '0;
    logic [CH-1:0]  err_flag = '0;
    logic           gen_rst_n;
    logic [7:0]     test_len_ctrl;
    logic           test_run_ctrl;
    logic           busy;
    logic           done;
    logic           pass;
    logic           aborted;
    logic [CH-1:0]  chnl_fail;
    logic [CH*EW-1:0] err_cnt;

    gtx_test_seq_ctrl #(
        .CHNL_NUM(CH), .RST_CYC(RST), .SETTLE_CYC(SET), .DRAIN_CYC(DRN), .ERR_W(EW)
    ) dut (
        .usrclk(usrclk), .usrrst(usrrst), .start(start), .abort(abort),
        .run_cycles(run_cycles), .test_len(test_len), .chnl_en(chnl_en), .err_flag(err_flag),
        .gen_rst_n(gen_rst_n), .test_len_ctrl(test_len_ctrl), .test_run_ctrl(test_run_ctrl),
        .busy(busy), .done(done), .pass(pass), .aborted(aborted),
        .chnl_fail(chnl_fail), .err_cnt(err_cnt)
    );

    always #5 usrclk = ~usrclk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;

    // Reference model: a test is "k cycles since the start edge"; the phase follows from k.
    bit        m_rst, m_act, m_done, m_abt, m_pass;
    int        m_k;
    longint    m_len;
    bit [CH-1:0] m_en, m_fail;
    bit [7:0]  m_tl;
    int        m_err [CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    function automatic int phase_at(int k);
        longint kk = k;
        if (kk < RST) return PH_RESET;
        if (kk < RST + SET) return PH_SETTLE;
        if (m_len == 0) return PH_RUN;
        if (kk < RST + SET + m_len) return PH_RUN;
        if (kk < RST + SET + m_len + DRN) return PH_DRAIN;
        return PH_DONE;
    endfunction

    function automatic int cur_ph();
        if (m_done) return PH_DONE;
        if (!m_act) return PH_IDLE;
        return phase_at(m_k);
    endfunction

    function automatic logic [CH*EW-1:0] exp_cnt();
        logic [CH*EW-1:0] v;
        for (int i = 0; i < CH; i++) v[i*EW +: EW] = EW'(m_err[i]);
        return v;
    endfunction

    task automatic model_clear();
        m_rst = 1; m_act = 0; m_done = 0; m_abt = 0; m_pass = 0;
        m_k = 0; m_len = 0; m_en = '0; m_fail = '0; m_tl = '0;
        for (int i = 0; i < CH; i++) m_err[i] = 0;
    endtask

    task automatic finish_test(input bit ab);
        m_act = 0; m_done = 1; m_abt = ab;
        for (int i = 0; i < CH; i++) m_fail[i] = (m_err[i] != 0) && m_en[i];
        m_pass = !ab && (m_fail == '0);
    endtask

    task automatic check_outs();
        chk("gen_rst_n", gen_rst_n, !m_rst && !(m_act && phase_at(m_k) == PH_RESET));
        chk("test_run_ctrl", test_run_ctrl, m_act && phase_at(m_k) == PH_RUN);
        chk("busy", busy, m_act || m_done);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("aborted", aborted, m_abt);
        chk("chnl_fail", chnl_fail, m_fail);
        chk("test_len_ctrl", test_len_ctrl, m_tl);
        chk("err_cnt", err_cnt, exp_cnt());
    endtask

    task automatic tick();
        int ph;
        ph = cur_ph();
        @(posedge usrclk);
        if (usrrst) model_clear();
        else begin
            m_rst = 0;
            if (m_done) m_done = 0;
            else if (!m_act) begin
                if (start) begin
                    m_act = 1; m_k = 0; m_len = run_cycles; m_en = chnl_en; m_tl = test_len;
                    m_pass = 0; m_abt = 0; m_fail = '0;
                    for (int i = 0; i < CH; i++) m_err[i] = 0;
                end
            end else begin
                if (ph == PH_RUN || ph == PH_DRAIN)
                    for (int i = 0; i < CH; i++)
                        if (err_flag[i] && m_err[i] < EMAX) m_err[i]++;
                if (abort) finish_test(1);
                else begin
                    m_k++;
                    if (phase_at(m_k) == PH_DONE) finish_test(0);
                end
            end
        end
        #1;
        cyc_n++;
        check_outs();
    endtask

    // mode: 0 quiet, 1 lane2/lane5 pattern, 2 lane0 held in RUN + SETTLE noise,
    //       3 random errors/aborts/starts, 4 random errors only
    task automatic do_test(input int rc, input bit [CH-1:0] en, input int mode, input int abort_at,
                           input bit busy_start, output int done_off, output int glow, output int rhigh);
        int s, budget, ph, ridx, didx;
        run_cycles = rc; chnl_en = en; test_len = 8'($urandom);
        s = cyc_n; glow = 0; rhigh = 0; budget = 0;
        start = 1;
        abort = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        err_flag = CH'($urandom);
        tick();
        if (!gen_rst_n) glow++;
        while (!m_done && budget < 5000) begin
            ph = cur_ph(); ridx = m_k - (RST + SET); didx = ridx - rc;
            run_cycles = $urandom; chnl_en = CH'($urandom); test_len = 8'($urandom);
            case (mode)
                0: err_flag = '0;
                1: begin
                    err_flag = '0;
                    err_flag[2] = (ph == PH_RUN) && (ridx < 3);
                    err_flag[5] = (ph == PH_DRAIN) && (didx < 2);
                end
                2: err_flag = (ph == PH_RUN) ? CH'(1) : ((ph == PH_SETTLE) ? '1 : '0);
                default: err_flag = CH'($urandom) & CH'($urandom);
            endcase
            abort = ((abort_at >= 0) && (ph == PH_RUN) && (ridx == abort_at)) ||
                    ((mode == 3) && ($urandom_range(0, 99) == 0));
            start = busy_start || ((mode == 3) && ($urandom_range(0, 3) == 0));
            tick();
            if (!gen_rst_n) glow++;
            if (test_run_ctrl) rhigh++;
            budget++;
        end
        if (!m_done) chk("timeout", 0, 1);
        done_off = cyc_n - s;
        start = 0; abort = 0;
        err_flag = CH'($urandom) | CH'(1);
        tick(); tick();
        err_flag = '0;
    endtask

    initial begin
        int d, gl, rh;
        model_clear();

        // 1: reset values and idle
        repeat (3) tick();
        chk("rst_gen_rst_n", gen_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        usrrst = 0; abort = 1;
        tick(); tick();
        abort = 0;
        chk("idle_gen_rst_n", gen_rst_n, 1);
        chk("idle_busy", busy, 0);

        // 2: clean run
        do_test(100, '1, 0, -1, 0, d, gl, rh);
        chk("t2_done_at", d, 1 + RST + SET + 100 + DRN);
        chk("t2_gen_low", gl, 4);
        chk("t2_run_high", rh, 100);
        chk("t2_pass", pass, 1);
        chk("t2_err_cnt", err_cnt, 0);

        // 3: errors and mask
        do_test(20, 8'hDF, 1, -1, 0, d, gl, rh);
        chk("t3_lane2", err_cnt[2*EW +: EW], 3);
        chk("t3_lane5", err_cnt[5*EW +: EW], 2);
        chk("t3_chnl_fail", chnl_fail, 8'h04);
        chk("t3_pass", pass, 0);

        // 4: saturation; settle and post-done pulses ignored
        do_test(40, '1, 2, -1, 0, d, gl, rh);
        chk("t4_lane0_sat", err_cnt[EW-1:0], 15);
        chk("t4_chnl_fail", chnl_fail, 8'h01);

        // 5: run_cycles=0 with abort, start held high while busy
        do_test(0, '1, 0, 500, 1, d, gl, rh);
        chk("t5_done_at", d, 1 + RST + SET + 501);
        chk("t5_run_high", rh, 501);
        chk("t5_aborted", aborted, 1);
        chk("t5_pass", pass, 0);
        chk("t5_run_ctrl", test_run_ctrl, 0);

        // randomized runs
        for (int n = 0; n < 6; n++) begin
            do_test($urandom_range(1, 60), CH'($urandom), 3, -1, 0, d, gl, rh);
        end

        // 6: async reset mid-RUN, then a normal test
        run_cycles = 200; chnl_en = '1; start = 1;
        tick();
        start = 0;
        for (int b = 0; b < 300 && !(cur_ph() == PH_RUN && m_k >= RST + SET + 20); b++) begin
            err_flag = CH'($urandom);
            tick();
        end
        err_flag = '0;
        #2 usrrst = 1;
        #1;
        chk("t6_run_ctrl", test_run_ctrl, 0);
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_busy", busy, 0);
        model_clear();
        tick();
        usrrst = 0;
        tick();
        do_test(60, CH'($urandom), 4, -1, 0, d, gl, rh);
        chk("t6_done_at", d, 1 + RST + SET + 60 + DRN);
        chk("t6_aborted", aborted, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
